// File: rtl/wb_timer_pkg.sv
// Shared constants and helpers for the memory-mapped machine timer.
package wb_timer_pkg;

  localparam int unsigned BUS_W      = 32;
  localparam int unsigned SEL_W      = BUS_W / 8;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned IDX_W      = 3;

  // Bus slot where memory_system places the timer
  localparam logic [31:0] TIMER_SLOT_BASE = 32'h0200_0000;

  // Register byte offsets within the slot
  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_PRESCALE    = 5'h14;
  localparam logic [4:0] OFF_RSVD0       = 5'h18;

  // ctrl register bit positions
  localparam int unsigned CTRL_COUNT_EN_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;

  localparam logic [63:0] MTIMECMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  // One decoded bus request
  typedef struct packed {
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic [BUS_W-1:0] data;
  } wb_req_t;

  // Replace only the byte lanes enabled in sel
  function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_w,
                                                  input logic [BUS_W-1:0] new_w,
                                                  input logic [SEL_W-1:0] sel);
    logic [BUS_W-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock: tick fires once every (prescale+1) enabled cycles.
module timer_prescaler
  import wb_timer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  // Tick is combinational so mtime advances in the cycle the count matches
  assign tick = en && (count == prescale);

  // Count up while enabled, wrap on match; a config write restarts the period
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone-attached 64-bit machine timer with compare interrupt.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter logic [63:0] MTIMECMP_RST = MTIMECMP_RST_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [XLEN/8-1:0] i_wb_sel,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_data,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic              o_wb_err,
  output logic              o_irq
);

  wb_req_t               req_c;
  logic                  bad_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  clr_c;
  logic                  tick;
  logic [BUS_W-1:0]      rdata_c;
  logic                  unused_addr_c;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  count_en;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;

  assign req_c.we   = i_wb_we;
  assign req_c.sel  = SEL_W'(i_wb_sel);
  assign req_c.idx  = i_addr[4:2];
  assign req_c.data = BUS_W'(i_data);

  assign unused_addr_c = ^{i_addr[XLEN-1:5], i_addr[1:0]};
  assign o_wb_stall    = 1'b0;

  // Decode: the top two slots of the window are reserved and answer with err
  assign bad_c = (req_c.idx >= OFF_RSVD0[4:2]);
  assign wr_c  = i_wb_stb && req_c.we && !bad_c;
  assign rd_c  = i_wb_stb && !req_c.we && !bad_c;
  assign clr_c = wr_c && ((req_c.idx == OFF_CTRL[4:2]) || (req_c.idx == OFF_PRESCALE[4:2]));

  timer_prescaler u_prescaler (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .en       (count_en),
    .clr      (clr_c),
    .prescale (prescale),
    .tick     (tick)
  );

  // Read mux; writes and errors return zero
  always_comb begin
    rdata_c = '0;
    if (rd_c) begin
      case (req_c.idx)
        OFF_MTIME_LO[4:2]:    rdata_c = mtime[31:0];
        OFF_MTIME_HI[4:2]:    rdata_c = hi_shadow;
        OFF_MTIMECMP_LO[4:2]: rdata_c = mtimecmp[31:0];
        OFF_MTIMECMP_HI[4:2]: rdata_c = mtimecmp[63:32];
        OFF_CTRL[4:2]: begin
          rdata_c[CTRL_COUNT_EN_BIT] = count_en;
          rdata_c[CTRL_IRQ_EN_BIT]   = irq_en;
        end
        OFF_PRESCALE[4:2]:    rdata_c = BUS_W'(prescale);
        default:              rdata_c = '0;
      endcase
    end
  end

  // Single-cycle response: ack or err plus registered read data
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= i_wb_stb && !bad_c;
      o_wb_err  <= i_wb_stb && bad_c;
      o_wb_data <= XLEN'(rdata_c);
    end
  end

  // mtime: bus write has priority over the tick increment
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mtime <= '0;
    end else if (wr_c && (req_c.idx == OFF_MTIME_LO[4:2])) begin
      mtime[31:0] <= byte_merge(mtime[31:0], req_c.data, req_c.sel);
    end else if (wr_c && (req_c.idx == OFF_MTIME_HI[4:2])) begin
      mtime[63:32] <= byte_merge(mtime[63:32], req_c.data, req_c.sel);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Capture the upper half on a low read so a 64-bit read pair is coherent
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      hi_shadow <= '0;
    end else if (rd_c && (req_c.idx == OFF_MTIME_LO[4:2])) begin
      hi_shadow <= mtime[63:32];
    end
  end

  // Compare value and configuration registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mtimecmp <= MTIMECMP_RST;
      count_en <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
    end else if (wr_c) begin
      case (req_c.idx)
        OFF_MTIMECMP_LO[4:2]: mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], req_c.data, req_c.sel);
        OFF_MTIMECMP_HI[4:2]: mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], req_c.data, req_c.sel);
        OFF_CTRL[4:2]: begin
          if (req_c.sel[0]) begin
            count_en <= req_c.data[CTRL_COUNT_EN_BIT];
            irq_en   <= req_c.data[CTRL_IRQ_EN_BIT];
          end
        end
        OFF_PRESCALE[4:2]: begin
          if (req_c.sel[0]) prescale[7:0]  <= req_c.data[7:0];
          if (req_c.sel[1]) prescale[15:8] <= req_c.data[15:8];
        end
        default: ;
      endcase
    end
  end

  // Interrupt follows the current register values with one cycle of latency
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= irq_en && (mtime >= mtimecmp);
    end
  end

endmodule
